// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: word-addressed data memory with a programmable wait-state stall controller.
// Optional alignment fault detection is enabled by defining DMEM_ALIGN_CHECK_EN.
`default_nettype none

module dmem_wait_ctrl #(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] MD_out,
    output logic        stall,
    output logic        misaligned,
    output logic [15:0] access_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic       C_HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] C_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] access_cnt_q;
    logic [31:0] mem_q [DEPTH];

    logic          w_act;
    logic          w_fault;
    logic          w_stall;
    logic          w_complete;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    // Reset masks the request so nothing stalls, faults or commits during a reset cycle.
    assign w_act         = (mem_read | mem_write) & ~rst;
    assign w_idx         = addr[AW+1:2];
    assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic sticky_q;

    assign w_fault    = w_act & (addr[1:0] != 2'b00);
    assign misaligned = w_fault | sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (w_fault) begin
            sticky_q <= 1'b1;
        end
    end
`else
    assign w_fault    = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_stall = 1'b0;
        if (w_act && !w_fault) begin
            case (state_q)
                IDLE: begin
                    if (C_HAS_WAIT) begin
                        w_stall = 1'b1;
                        cnt_d   = C_WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        w_stall = 1'b1;
                        cnt_d   = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            // Withdrawn request or fault: abandon any pending wait sequence.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end
    end

    assign w_complete = w_act & ~w_fault & ~w_stall;
    assign stall      = w_stall;
    assign access_cnt = access_cnt_q;
    assign MD_out     = (mem_read && !w_fault) ? mem_q[w_idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            access_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_complete) begin
                access_cnt_q <= access_cnt_q + 16'd1;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_complete && mem_write) begin
            mem_q[w_idx] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_wait_ctrl.md
Name: dmem_wait_ctrl

Overview:
- Word-addressed data memory with a programmable wait-state controller.
- Sits directly downstream of the single-cycle datapath:
  - consumes `alu_out` as the byte address and `Read2` as the store data;
  - returns `MD_out` for load writeback.
- Raises `stall` so the processor holds PC and register-file writes until the access completes.
- Models slow memory without changing the datapath's single-cycle writeback timing.

Parameters:
- `DEPTH`, 256, number of 32-bit words; must be a power of two.
- `AW`, 8, word-index width, log2(`DEPTH`).
- `WAIT_CYCLES`, 2, stall cycles inserted before each access completes (0..15).

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `mem_read`  input  1  load request.
- `mem_write`  input  1  store request.
- `addr`  input  32  byte address (datapath `alu_out`).
- `wdata`  input  32  store data (datapath `Read2`).
- `MD_out`  output  32  load data to writeback mux.
- `stall`  output  1  hold PC/regfile while 1.
- `misaligned`  output  1  alignment fault flag; see Optional Feature.
- `access_cnt`  output  16  completed-access counter.

Behaviour:
- Clocking and reset:
  - One clock `clk`; reset `rst` is synchronous and active-high.
  - All state updates on the rising edge of `clk`.
- Request and word index:
  - `req = mem_read | mem_write`.
  - Word index = `addr[AW+1:2]`; upper address bits are ignored, so addresses wrap modulo `DEPTH`.
- FSM states: IDLE, WAIT. 4-bit down-counter `cnt`.
- IDLE, `req`=0: `stall`=0; stay in IDLE.
- IDLE, `req`=1, `WAIT_CYCLES`=0: `stall`=0; access completes at this edge; stay in IDLE.
- IDLE, `req`=1, `WAIT_CYCLES`>0: `stall`=1 (combinational, same cycle); `cnt`<=`WAIT_CYCLES`-1; go to WAIT.
- WAIT, `req`=1, `cnt`!=0: `stall`=1; `cnt`<=`cnt`-1.
- WAIT, `req`=1, `cnt`=0: `stall`=0; access completes at this edge; go to IDLE.
- WAIT, `req`=0 (request withdrawn): `stall`=0; abort to IDLE; no write; `access_cnt` unchanged.
- Completion cycle = the cycle with `req`=1 and `stall`=0:
  - store: `mem[idx]`<=`wdata` at that edge;
  - `access_cnt` increments by 1 and wraps from 0xFFFF to 0.
- The datapath holds `addr`, `wdata` and request signals stable while `stall`=1. The block does not latch them; the completion cycle uses the current values.
- Read data (asynchronous read):
  - `MD_out` = `mem[idx]` when `mem_read`=1, else 32'd0.
  - `MD_out` is valid in the completion cycle and also during stall cycles (the datapath ignores it then).
- Simultaneous `mem_read`=1 and `mem_write`=1:
  - the store commits at the completion edge;
  - `MD_out` shows the pre-write contents (read-before-write).
  - Counts as one access.
- Back-to-back requests: after completion the FSM is in IDLE, so the next cycle's request starts a fresh wait sequence. There is no idle bubble and no missed request.
- Reset:
  - outputs: `stall`=0, `access_cnt`=0, `misaligned`=0; `MD_out` follows its combinational rule;
  - FSM state IDLE, `cnt`=0;
  - memory contents are not cleared;
  - reset asserted during WAIT aborts the pending access, with no write.
- Latency: each access occupies `WAIT_CYCLES`+1 cycles.

Optional Feature:
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined:
  - a request with `addr[1:0]`!=0 is a fault;
  - a fault completes immediately from IDLE (`stall`=0, no wait states);
  - no write occurs;
  - `MD_out`=0;
  - `access_cnt` is not incremented;
  - `misaligned`=1 combinationally in that cycle, and a sticky copy is held in a register until `rst`. The `misaligned` port reports the OR of the two.
- Undefined:
  - `addr[1:0]` is ignored;
  - `misaligned` is tied to 0.

Test Plan:
- Reset, then `WAIT_CYCLES`=2, store `addr`=0x10, `wdata`=0xDEADBEEF → `stall`=1,1,0 over 3 cycles; `mem[4]`=0xDEADBEEF after the 3rd edge; `access_cnt`=1.
- Load `addr`=0x10 → `stall` 1,1,0; `MD_out`=0xDEADBEEF in the 3rd cycle; `access_cnt`=2.
- Store 0x11111111 to `addr`=0x400 with `DEPTH`=256 → wraps to word 0; a load of `addr`=0x0 returns 0x11111111.
- Store request dropped after 1 stall cycle, then `rst` pulsed mid-WAIT on a second store → no memory change; `stall`=0; FSM IDLE; `access_cnt` unchanged.
- `mem_read`=`mem_write`=1 at `addr`=0x10 with `wdata`=0x12345678 → `MD_out`=0xDEADBEEF in the completion cycle; a subsequent load returns 0x12345678.
- With `DMEM_ALIGN_CHECK_EN` defined, store to `addr`=0x13 → `stall`=0, `misaligned`=1 and sticky until `rst`, word 4 unchanged, `access_cnt` unchanged.
